sram_ctrl: RTL and testbench

- Responder side of the 32-bit SRAM request interface driven by the cache controller in the memory stage.
- Accepts one word read or write per request.
- Serializes each request into two 16-bit accesses on the external asynchronous SRAM chip (256K x 16), with a fixed number of wait states per halfword.
- Returns a one-cycle ready pulse when the word transfer is complete.

---
 rtl/sram_ctrl.sv | 141 ++++++++++++++
 tb/tb_sram_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - 32-bit request responder serialising words onto a 16-bit async SRAM
module sram_ctrl #(
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] DATA_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        write_en,
  input  logic        read_en,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [16:0] word_q, word_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;

  // Only the low 19 bits of the offset matter: the chip spans 2^19 bytes and
  // higher bits wrap silently, so the subtraction is done at that width.
  logic [18:0] off;
  logic        phase_end;
  logic        unused_bits;
  logic        dq_en;
  logic [15:0] dq_out;

  assign off         = address[18:0] - DATA_BASE[18:0];
  assign unused_bits = ^{address[31:19], off[1:0]};
  assign phase_end   = (cnt_q == LAST);

  // Next-state: accept in IDLE (write has priority), count wait states per
  // halfword phase, capture read halves on the phase-ending edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (write_en) begin
          wr_d    = 1'b1;
          word_d  = off[18:2];
          wdata_d = write_data;
          cnt_d   = 4'd0;
          state_d = LOW;
        end else if (read_en) begin
          wr_d    = 1'b0;
          word_d  = off[18:2];
          cnt_d   = 4'd0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (phase_end) begin
          cnt_d   = 4'd0;
          state_d = HIGH;
          if (!wr_q) rdata_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          cnt_d   = 4'd0;
          state_d = DONE;
          if (!wr_q) rdata_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and latched request; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      word_q  <= 17'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Chip pins decoded from state; WE_N rises for the last cycle of a write
  // phase so address and data stay stable across its rising edge.
  always_comb begin
    SRAM_ADDR = 18'd0;
    SRAM_CE_N = 1'b1;
    SRAM_OE_N = 1'b1;
    SRAM_WE_N = 1'b1;
    dq_en     = 1'b0;
    dq_out    = 16'd0;
    if (state_q == LOW || state_q == HIGH) begin
      SRAM_ADDR = {word_q, (state_q == HIGH)};
      SRAM_CE_N = 1'b0;
      if (wr_q) begin
        dq_en     = 1'b1;
        dq_out    = (state_q == HIGH) ? wdata_q[31:16] : wdata_q[15:0];
        SRAM_WE_N = !(cnt_q < LAST);
      end else begin
        SRAM_OE_N = 1'b0;
      end
    end
  end

  assign SRAM_DQ   = dq_en ? dq_out : 16'bz;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign ready     = (state_q == DONE);
  assign read_data = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - scoreboard bench for sram_ctrl at two wait-state settings
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst;
  logic [1:0][31:0]  address;
  logic [1:0][31:0]  write_data;
  logic [1:0]        write_en;
  logic [1:0]        read_en;
  logic [1:0][31:0]  read_data;
  logic [1:0]        ready;
  logic [1:0][17:0]  sram_addr;
  logic [1:0]        ub_n, lb_n, we_n, ce_n, oe_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed { int cyc; logic [31:0] rd; } rdy_t;
  typedef struct packed { logic [17:0] hw; logic wr; } ph_t;

  rdy_t rq [2][$];
  ph_t  pq [2][$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int WC = (k == 0) ? 2 : 4;
    wire  [15:0] dq;
    logic [15:0] mem [0:1023];

    sram_ctrl #(.WAIT_CYCLES(WC), .DATA_BASE(32'd1024)) dut (
      .clk(clk), .rst(rst[k]), .address(address[k]), .write_data(write_data[k]),
      .write_en(write_en[k]), .read_en(read_en[k]), .read_data(read_data[k]),
      .ready(ready[k]), .SRAM_DQ(dq), .SRAM_ADDR(sram_addr[k]),
      .SRAM_UB_N(ub_n[k]), .SRAM_LB_N(lb_n[k]), .SRAM_WE_N(we_n[k]),
      .SRAM_CE_N(ce_n[k]), .SRAM_OE_N(oe_n[k])
    );

    // Async SRAM: drives on CE&OE, latches on the rising edge of WE_N.
    assign dq = (!ce_n[k] && !oe_n[k]) ? mem[sram_addr[k][9:0]] : 16'bz;
    always @(posedge we_n[k]) if (!ce_n[k]) mem[sram_addr[k][9:0]] <= dq;

    // Ready monitor: pops expected completion cycle and read word.
    bit   prev_rdy = 1'b0;
    rdy_t e;
    always @(negedge clk) begin
      if (ready[k]) begin
        if (prev_rdy) fail_now($sformatf("ready_width[%0d] ready high two cycles", k));
        if (rq[k].size() == 0) begin
          fail_now($sformatf("ready_unexpected[%0d] at cycle %0d", k, cyc));
        end else begin
          e = rq[k].pop_front();
          chk($sformatf("ready_cycle[%0d]", k), cyc, e.cyc);
          chk($sformatf("read_data[%0d]", k), read_data[k], e.rd);
        end
      end
      prev_rdy = ready[k];
    end

    // Phase monitor: address sequence, phase length, strobe shape, read bus.
    int          idx = 0;
    bit          in_ph = 1'b0;
    ph_t         cur = '0;
    logic [17:0] cur_addr = '0;
    always @(negedge clk) begin
      if (!oe_n[k] && !we_n[k]) fail_now($sformatf("oe_we_overlap[%0d]", k));
      if (rst[k]) begin
        in_ph = 1'b0;
      end else if (!ce_n[k]) begin
        if (!in_ph || sram_addr[k] != cur_addr) begin
          if (in_ph) chk($sformatf("phase_len[%0d]", k), idx + 1, WC);
          if (pq[k].size() == 0) begin
            fail_now($sformatf("phase_unexpected[%0d] addr %h", k, sram_addr[k]));
            cur = '0;
          end else begin
            cur = pq[k].pop_front();
            chk($sformatf("phase_addr[%0d]", k), 32'(sram_addr[k]), 32'(cur.hw));
          end
          cur_addr = sram_addr[k];
          idx      = 0;
          in_ph    = 1'b1;
        end else begin
          idx++;
        end
        chk($sformatf("oe_n[%0d]", k), 32'(oe_n[k]), 32'(cur.wr));
        chk($sformatf("we_n[%0d] idx %0d", k, idx), 32'(we_n[k]),
            cur.wr ? 32'(idx >= WC - 1) : 32'd1);
        if (!cur.wr) chk($sformatf("read_dq[%0d]", k), 32'(dq), 32'(mem[sram_addr[k][9:0]]));
      end else if (in_ph) begin
        chk($sformatf("phase_len[%0d]", k), idx + 1, WC);
        in_ph = 1'b0;
      end
    end
  end

  function automatic logic [15:0] memv(input int k, input int a);
    return (k == 0) ? g[0].mem[a] : g[1].mem[a];
  endfunction

  // Issue one request; expected ready cycle, read word and halfword phases
  // are queued for the monitors. Returns one cycle after the ready pulse.
  task automatic req(input int k, input bit we, input bit re, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] rd_exp,
                     input logic [17:0] hw, input bit hold);
    int   w;
    bit   seen;
    rdy_t r;
    ph_t  p;
    w    = (k == 0) ? 2 : 4;
    seen = 1'b0;
    address[k]    = a;
    write_data[k] = d;
    write_en[k]   = we;
    read_en[k]    = re;
    p.wr = we;
    p.hw = hw;            pq[k].push_back(p);
    p.hw = hw | 18'd1;    pq[k].push_back(p);
    r.cyc = cyc + 1 + 2 * w;
    r.rd  = rd_exp;
    rq[k].push_back(r);
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      seen = ready[k];
    end
    if (!seen) fail_now($sformatf("ready_timeout[%0d] addr %h", k, a));
    @(posedge clk); #1;
    if (!hold) begin
      write_en[k] = 1'b0;
      read_en[k]  = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 2'b11;
    address    = '0;
    write_data = '0;
    write_en   = '0;
    read_en    = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready[%0d]", k), 32'(ready[k]), 32'd0);
      chk($sformatf("rst_read_data[%0d]", k), read_data[k], 32'd0);
      chk($sformatf("rst_addr[%0d]", k), 32'(sram_addr[k]), 32'd0);
      chk($sformatf("rst_strobes[%0d]", k), 32'({we_n[k], ce_n[k], oe_n[k]}), 32'b111);
      chk($sformatf("rst_byte_en[%0d]", k), 32'({ub_n[k], lb_n[k]}), 32'b00);
    end
    rst = 2'b00;
    @(posedge clk); #1;

    // Basic write then read, WAIT_CYCLES=2.
    req(0, 1, 0, 32'd1024, 32'hDEADBEEF, 32'h0000_0000, 18'd0, 0);
    chk("mem_hw0", 32'(memv(0, 0)), 32'h0000BEEF);
    chk("mem_hw1", 32'(memv(0, 1)), 32'h0000DEAD);
    req(0, 0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 0);

    // Back-to-back reads with read_en held across the ready pulse.
    req(0, 1, 0, 32'd1028, 32'hA5A55A5A, 32'hDEADBEEF, 18'd2, 0);
    req(0, 0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 1);
    req(0, 0, 1, 32'd1028, 32'h0, 32'hA5A55A5A, 18'd2, 0);

    // Address map: ignored byte offset, word 4, wraparound.
    req(0, 0, 1, 32'd1027, 32'h0, 32'hDEADBEEF, 18'd0, 0);
    req(0, 1, 0, 32'd1040, 32'h13579BDF, 32'hDEADBEEF, 18'd8, 0);
    chk("mem_hw8", 32'(memv(0, 8)), 32'h00009BDF);
    chk("mem_hw9", 32'(memv(0, 9)), 32'h00001357);
    req(0, 0, 1, 32'd1024 + 32'h0008_0000, 32'h0, 32'hDEADBEEF, 18'd0, 0);

    // Both enables: write wins, read_data untouched.
    req(0, 1, 1, 32'd1032, 32'h12345678, 32'hDEADBEEF, 18'd4, 0);
    chk("mem_hw4", 32'(memv(0, 4)), 32'h00005678);
    chk("mem_hw5", 32'(memv(0, 5)), 32'h00001234);
    chk("rd_after_write", read_data[0], 32'hDEADBEEF);

    // Reset in the second cycle of a write HIGH phase.
    begin
      ph_t p;
      address[0]    = 32'd1048;
      write_data[0] = 32'hCAFEF00D;
      write_en[0]   = 1'b1;
      p.wr = 1'b1;
      p.hw = 18'd12; pq[0].push_back(p);
      p.hw = 18'd13; pq[0].push_back(p);
      repeat (4) @(posedge clk);
      #1;
      rst[0] = 1'b1;
      #1;
      chk("abort_we_n", 32'(we_n[0]), 32'd1);
      chk("abort_ce_n", 32'(ce_n[0]), 32'd1);
      chk("abort_oe_n", 32'(oe_n[0]), 32'd1);
      chk("abort_ready", 32'(ready[0]), 32'd0);
      chk("abort_read_data", read_data[0], 32'd0);
      write_en[0] = 1'b0;
      @(posedge clk); #1;
      rst[0] = 1'b0;
      @(posedge clk); #1;
    end
    req(0, 0, 1, 32'd1024, 32'h0, 32'hDEADBEEF, 18'd0, 0);

    // WAIT_CYCLES=4 instance.
    req(1, 1, 0, 32'd1036, 32'h89ABCDEF, 32'h0000_0000, 18'd6, 0);
    chk("mem4_hw6", 32'(memv(1, 6)), 32'h0000CDEF);
    chk("mem4_hw7", 32'(memv(1, 7)), 32'h000089AB);
    req(1, 0, 1, 32'd1036, 32'h0, 32'h89ABCDEF, 18'd6, 0);

    repeat (4) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ready_queue_empty[%0d]", k), 32'(rq[k].size()), 32'd0);
      chk($sformatf("phase_queue_empty[%0d]", k), 32'(pq[k].size()), 32'd0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
